load_store_unit: RTL and testbench

- Initiator-side master for the single-cycle-read, posedge-write data memory.
- Accepts load/store requests from the CPU pipeline over a valid/ready handshake.
- Drives the memory's mem_read/mem_write/address/write_data, and returns sign/zero-extended load data over a valid/ready response channel.
- Byte and halfword stores use read-modify-write, because the memory is word-only.

---
 rtl/load_store_unit.sv | 158 +++++++++++++++
 tb/tb_load_store_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: CPU-side load/store master for a word-only data memory.
// Optional build macro: LSU_MISALIGN_CHECK_EN (reject misaligned half/word).
`timescale 1ns/1ps
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = {ADDR_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_write_data,
    input  logic [31:0]           mem_read_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t                state;
    logic                  we_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           merge_q;

    logic                  bad_req;
    logic [7:0]            byte_v;
    logic [15:0]           half_v;
    logic [31:0]           load_v;
    logic [31:0]           merged;
    logic                  in_access;

    // Classify the incoming request as rejected (reserved size / misaligned)
    always_comb begin
        bad_req = (req_size == 2'b11);
`ifdef LSU_MISALIGN_CHECK_EN
        if (req_size == 2'b01 && req_addr[0])
            bad_req = 1'b1;
        if (req_size == 2'b10 && req_addr[1:0] != 2'b00)
            bad_req = 1'b1;
`endif
    end

    // Pick the addressed lane out of the read word and extend it
    always_comb begin
        byte_v = mem_read_data[{addr_q[1:0], 3'b000} +: 8];
        half_v = addr_q[1] ? mem_read_data[31:16]
                           : mem_read_data[15:0];
        case (size_q)
            2'b00:   load_v = uns_q ? {24'b0, byte_v}
                                    : {{24{byte_v[7]}}, byte_v};
            2'b01:   load_v = uns_q ? {16'b0, half_v}
                                    : {{16{half_v[15]}}, half_v};
            default: load_v = mem_read_data;
        endcase
    end

    // Splice the store lane into the previously read word
    always_comb begin
        merged = merge_q;
        case (size_q)
            2'b00:
                merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01:
                merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default:
                merged = wdata_q;
        endcase
    end

    assign in_access = !reset && (state == RD || state == WR);

    assign req_ready = !reset && (state == IDLE);
    assign mem_read  = !reset && (state == RD);
    assign mem_write = !reset && (state == WR);

    assign mem_address = in_access ? {addr_q[ADDR_WIDTH-1:2], 2'b00}
                                   : RESET_ADDR;
    assign mem_write_data = mem_write ? merged : 32'h0;

    // Request sequencer with registered response outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            addr_q     <= {ADDR_WIDTH{1'b0}};
            wdata_q    <= 32'h0;
            merge_q    <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q       <= req_we;
                        size_q     <= req_size;
                        uns_q      <= req_unsigned;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        resp_rdata <= 32'h0;
                        resp_err   <= 1'b0;
                        if (bad_req) begin
                            resp_err   <= 1'b1;
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end else if (req_we && req_size == 2'b10) begin
                            state <= WR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    if (we_q) begin
                        merge_q <= mem_read_data;
                        state   <= WR;
                    end else begin
                        resp_rdata <= load_v;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                WR: begin
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: random load/store traffic against a byte-array model.
// Also covers directed round-trip, merge, extend, backpressure, reset cases.
`timescale 1ns/1ps
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] mem [64];
    logic [7:0]  rb  [256];

    int          n_chk = 0;
    int          n_err = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [31:0] last_wa = 32'h0;
    logic [31:0] last_wd = 32'h0;

    load_store_unit #(.ADDR_WIDTH(32), .RESET_ADDR(32'h0)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address),
        .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    assign mem_read_data = mem[mem_address[7:2]];

    always @(posedge clk)
        if (mem_write) mem[mem_address[7:2]] <= mem_write_data;

    always @(negedge clk) begin
        if (mem_read) rd_cnt++;
        if (mem_write) begin
            wr_cnt++;
            last_wa = mem_address;
            last_wd = mem_write_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int w);
        return {rb[4*w+3], rb[4*w+2], rb[4*w+1], rb[4*w]};
    endfunction

    task automatic poke(input int a, input logic [31:0] v);
        mem[a/4] = v;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] t;
            t = v >> (8 * i);
            rb[(a & ~3) + i] = t[7:0];
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz,
                          input logic uns, input int a,
                          input logic [31:0] wd, input int stall,
                          output logic [31:0] got);
        int          nb, ea, lat, rd0, wr0, exp_lat, exp_rd, exp_wr;
        logic        err;
        logic [31:0] val, t, held;
        err = (sz == 2'b11);
`ifdef LSU_MISALIGN_CHECK_EN
        if (sz == 2'b01 && (a % 2) != 0) err = 1'b1;
        if (sz == 2'b10 && (a % 4) != 0) err = 1'b1;
`endif
        nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        ea = a - (a % nb);
        val = 32'h0;
        if (!err && !we) begin
            for (int i = 0; i < nb; i++)
                val = val | (32'(rb[ea + i]) << (8 * i));
            if (!uns && nb < 4 && val[8 * nb - 1])
                val = val - (32'd1 << (8 * nb));
        end
        if (!err && we) begin
            for (int i = 0; i < nb; i++) begin
                t = wd >> (8 * i);
                rb[ea + i] = t[7:0];
            end
        end
        exp_lat = err ? 1 : (we && nb < 4) ? 3 : 2;
        exp_rd  = err ? 0 : (!we || nb < 4) ? 1 : 0;
        exp_wr  = (!err && we) ? 1 : 0;

        req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = 32'(a); req_wdata = wd; req_valid = 1'b1;
        resp_ready = 1'b0;
        check("req_ready_idle", {31'b0, req_ready}, 32'h1);
        rd0 = rd_cnt; wr0 = wr_cnt;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("rdata", resp_rdata, val);
        check("err", {31'b0, resp_err}, {31'b0, err});
        got = resp_rdata;
        held = resp_rdata;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            check("bp_valid", {31'b0, resp_valid}, 32'h1);
            check("bp_rdata", resp_rdata, held);
            check("bp_ready", {31'b0, req_ready}, 32'h0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("resp_drop", {31'b0, resp_valid}, 32'h0);
        check("rd_count", 32'(rd_cnt - rd0), 32'(exp_rd));
        check("wr_count", 32'(wr_cnt - wr0), 32'(exp_wr));
        check("mem_word", mem[ea / 4], ref_word(ea / 4));
    endtask

    initial begin
        logic [31:0] got;
        int          lat;
        for (int i = 0; i < 64; i++) poke(4 * i, $urandom);

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'b0, resp_valid}, 32'h0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_err", {31'b0, resp_err}, 32'h0);
        check("rst_ready", {31'b0, req_ready}, 32'h0);
        check("rst_mrd", {31'b0, mem_read}, 32'h0);
        check("rst_mwr", {31'b0, mem_write}, 32'h0);
        reset = 1'b0;
        #1;
        check("rst_ready_rel", {31'b0, req_ready}, 32'h1);
        check("rst_addr", mem_address, 32'h0);

        do_req(1'b1, 2'b10, 1'b0, 'h10, 32'hDEADBEEF, 0, got);
        check("sw_addr", last_wa, 32'h10);
        check("sw_data", last_wd, 32'hDEADBEEF);
        do_req(1'b0, 2'b10, 1'b0, 'h10, 32'h0, 0, got);
        check("lw_val", got, 32'hDEADBEEF);

        poke('h20, 32'h11223344);
        do_req(1'b1, 2'b00, 1'b0, 'h21, 32'h000000AA, 0, got);
        check("sb_data", last_wd, 32'h1122AA44);
        check("sb_addr", last_wa, 32'h20);
        do_req(1'b0, 2'b00, 1'b1, 'h21, 32'h0, 0, got);
        check("lbu_val", got, 32'h000000AA);
        do_req(1'b0, 2'b00, 1'b0, 'h21, 32'h0, 0, got);
        check("lb_val", got, 32'hFFFFFFAA);

        poke('h30, 32'h80017FFF);
        do_req(1'b0, 2'b01, 1'b0, 'h32, 32'h0, 0, got);
        check("lh_hi", got, 32'hFFFF8001);
        do_req(1'b0, 2'b01, 1'b1, 'h32, 32'h0, 0, got);
        check("lhu_hi", got, 32'h00008001);
        do_req(1'b0, 2'b01, 1'b0, 'h30, 32'h0, 5, got);
        check("lh_lo", got, 32'h00007FFF);

        do_req(1'b0, 2'b11, 1'b0, 'h10, 32'h0, 0, got);
        poke('h10, 32'hCAFEF00D);
        do_req(1'b0, 2'b10, 1'b0, 'h13, 32'h0, 0, got);
`ifndef LSU_MISALIGN_CHECK_EN
        check("lw_trunc", got, 32'hCAFEF00D);
`endif

        poke('h20, 32'h11223344);
        req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h21; req_wdata = 32'hAA; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("mid_rd", {31'b0, mem_read}, 32'h1);
        @(posedge clk); #1;
        check("mid_wr", {31'b0, mem_write}, 32'h1);
        reset = 1'b1;
        #1;
        check("mid_wr_gate", {31'b0, mem_write}, 32'h0);
        @(posedge clk); #1;
        check("mid_valid", {31'b0, resp_valid}, 32'h0);
        check("mid_err", {31'b0, resp_err}, 32'h0);
        check("mid_mem", mem[8], 32'h11223344);
        reset = 1'b0;
        #1;
        check("mid_ready", {31'b0, req_ready}, 32'h1);

        poke('h40, 32'h12345678);
        req_we = 1'b0; req_size = 2'b10; req_addr = 32'h40;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        check("rsp_rdata", resp_rdata, 32'h12345678);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rsp_rst_valid", {31'b0, resp_valid}, 32'h0);
        check("rsp_rst_rdata", resp_rdata, 32'h0);
        reset = 1'b0;
        #1;

        for (int n = 0; n < 200; n++) begin
            logic [1:0] sz;
            sz = ($urandom_range(0, 15) == 0) ? 2'b11
                                               : 2'($urandom_range(0, 2));
            do_req(1'($urandom), sz, 1'($urandom),
                   int'($urandom_range(0, 255)), $urandom,
                   int'($urandom_range(0, 3)), got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
